// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// latency limits and the counter width that covers them.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int LAT_MIN    = 1;
  localparam int LAT_MAX    = 7;
  localparam int CNT_W      = $clog2(LAT_MAX + 1);
  localparam int WORD_BYTES = 8;

endpackage

// File: rtl/dmem_responder_stdreg.sv
// Enabled register with synchronous active-high reset; used to hold the
// response payload from acceptance until the handshake completes.
module dmem_responder_stdreg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (i_en) q_d = i_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) q_q <= RST_VAL;
    else       q_q <= q_d;
  end

  assign o_q = q_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte-masked 64-bit storage with a
// fixed, parameterised response latency and a valid/ready response handshake.
//   state | meaning
//   IDLE  | ready for a request; the only state that accepts one
//   WAIT  | latency counting down after acceptance
//   RESP  | response presented, held until i_rsp_ready
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wen,
  input  logic [`CPU_WIDTH-1:0] i_req_addr,
  input  logic [`CPU_WIDTH-1:0] i_req_wdata,
  input  logic [7:0]            i_req_wmask,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [`CPU_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int                    AW         = $clog2(DEPTH);
  localparam logic [`CPU_WIDTH-1:0] ADDR_LIMIT = `CPU_WIDTH'(DEPTH) << 3;
  localparam logic [CNT_W-1:0]      CNT_LOAD   = (LAT > LAT_MIN) ? CNT_W'(LAT - 2) : '0;

  dmem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [`CPU_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic [AW-1:0]         word_idx;
  logic [`CPU_WIDTH-1:0] rdata_d;
  logic                  err_d;
  logic [`CPU_WIDTH:0]   rsp_q;
  logic                  unused_addr_lsb;

  assign o_req_ready     = (state_q == IDLE);
  // Reset wins over a coincident request so nothing is committed during reset.
  assign accept          = i_req_valid & o_req_ready & ~i_rst;
  assign in_range        = (i_req_addr < ADDR_LIMIT);
  assign word_idx        = i_req_addr[AW+2:3];
  assign unused_addr_lsb = ^i_req_addr[2:0];

  always_comb begin
    rdata_d = '0;
    err_d   = ~in_range;
    if (in_range && !i_req_wen) rdata_d = mem[word_idx];
  end

  always_ff @(posedge i_clk) begin
    if (accept && i_req_wen && in_range) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (i_req_wmask[b]) mem[word_idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
      end
    end
  end

  dmem_responder_stdreg #(
    .WIDTH   (`CPU_WIDTH + 1),
    .RST_VAL ('0)
  ) u_rsp_reg (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (accept),
    .i_d   ({rdata_d, err_d}),
    .o_q   (rsp_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LAT == LAT_MIN) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rsp_q[`CPU_WIDTH:1];
  assign o_rsp_err   = rsp_q[0];

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LAT 1, 2, 7) driven one at a time
// and checked against a byte-array memory model and the latency rule.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

module tb_dmem_responder;

  localparam int N     = 3;
  localparam int DEPTH = 1024;
  localparam int NW    = 32;
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [N];
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_wen   [N];
  logic [63:0] req_addr  [N];
  logic [63:0] req_wdata [N];
  logic [7:0]  req_wmask [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [63:0] rsp_rdata [N];
  logic        rsp_err   [N];

  int checks = 0;
  int errors = 0;

  logic [63:0] model [N][DEPTH];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .DEPTH (DEPTH),
      .LAT   ((g == 0) ? 1 : ((g == 1) ? 2 : 7))
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst[g]),
      .i_req_valid (req_valid[g]),
      .o_req_ready (req_ready[g]),
      .i_req_wen   (req_wen[g]),
      .i_req_addr  (req_addr[g]),
      .i_req_wdata (req_wdata[g]),
      .i_req_wmask (req_wmask[g]),
      .o_rsp_valid (rsp_valid[g]),
      .i_rsp_ready (rsp_ready[g]),
      .o_rsp_rdata (rsp_rdata[g]),
      .o_rsp_err   (rsp_err[g])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 7);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle(int k);
    req_valid[k] = 1'b0;
    req_wen[k]   = 1'b0;
    req_addr[k]  = '0;
    req_wdata[k] = '0;
    req_wmask[k] = '0;
    rsp_ready[k] = 1'b0;
  endtask

  // Requests that a correct responder must ignore; accepting one would corrupt the model.
  task automatic junk(int k);
    req_valid[k] = 1'($urandom_range(0, 1));
    req_wen[k]   = 1'b1;
    req_addr[k]  = 64'($urandom_range(0, NW - 1)) << 3;
    req_wdata[k] = {$urandom, $urandom};
    req_wmask[k] = 8'hFF;
  endtask

  // Called at a negedge with the instance idle; returns at a negedge with it idle again.
  task automatic txn(input int k, input bit wen, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [7:0] mask,
                     input int hold, input string tag,
                     output logic [63:0] got_rdata, output logic got_err);
    bit          inr;
    int          wi;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          n;
    bit          seen;
    inr       = (addr < LIMIT);
    wi        = int'((addr >> 3) % 64'(DEPTH));
    exp_err   = !inr;
    exp_rdata = (inr && !wen) ? model[k][wi] : 64'h0;
    got_rdata = 'x;
    got_err   = 1'bx;

    chk({tag, "/req_ready"}, 64'(req_ready[k]), 64'h1);
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wmask[k] = mask;
    rsp_ready[k] = 1'b0;
    @(posedge clk);
    #1;
    if (inr && wen) begin
      for (int b = 0; b < 8; b++) begin
        if (mask[b]) model[k][wi][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    junk(k);
    rsp_ready[k] = 1'b0;

    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      junk(k);
      if (rsp_valid[k]) begin
        seen         = 1'b1;
        rsp_ready[k] = 1'b0;
      end else begin
        rsp_ready[k] = 1'($urandom_range(0, 1));
      end
    end
    chk({tag, "/latency"}, 64'(n), 64'(lat_of(k)));
    chk({tag, "/rdata"}, rsp_rdata[k], exp_rdata);
    chk({tag, "/err"}, 64'(rsp_err[k]), 64'(exp_err));
    chk({tag, "/busy"}, 64'(req_ready[k]), 64'h0);
    got_rdata = rsp_rdata[k];
    got_err   = rsp_err[k];

    for (int i = 0; i < hold; i++) begin
      rsp_ready[k] = 1'b0;
      junk(k);
      @(negedge clk);
      chk({tag, "/hold_valid"}, 64'(rsp_valid[k]), 64'h1);
      chk({tag, "/hold_rdata"}, rsp_rdata[k], exp_rdata);
      chk({tag, "/hold_err"}, 64'(rsp_err[k]), 64'(exp_err));
      chk({tag, "/hold_busy"}, 64'(req_ready[k]), 64'h0);
    end

    rsp_ready[k] = 1'b1;
    junk(k);
    @(negedge clk);
    chk({tag, "/done_valid"}, 64'(rsp_valid[k]), 64'h0);
    chk({tag, "/done_ready"}, 64'(req_ready[k]), 64'h1);
    drive_idle(k);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic        e;
    logic [63:0] v;
    logic [63:0] a;
    bit          w;

    for (int k = 0; k < N; k++) begin
      drive_idle(k);
      rst[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("reset/rsp_valid", 64'(rsp_valid[k]), 64'h0);
      chk("reset/rsp_rdata", rsp_rdata[k], 64'h0);
      chk("reset/rsp_err", 64'(rsp_err[k]), 64'h0);
      rst[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) chk("reset/req_ready_after", 64'(req_ready[k]), 64'h1);

    // Give every word the random traffic touches a known value.
    for (int k = 0; k < N; k++) begin
      for (int wd = 0; wd < NW; wd++) begin
        txn(k, 1'b1, 64'(wd) << 3, {$urandom, $urandom}, 8'hFF, 0, "init", r, e);
      end
    end

    // Directed cases on the LAT=2 instance.
    txn(1, 1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 0, "store_full", r, e);
    chk("store_full/rdata_zero", r, 64'h0);
    txn(1, 1'b0, 64'h10, 64'h0, 8'h00, 0, "load_full", r, e);
    chk("load_full/value", r, 64'h1122334455667788);
    txn(1, 1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, "store_mask", r, e);
    txn(1, 1'b0, 64'h17, 64'h0, 8'h00, 0, "load_mask", r, e);
    chk("load_mask/value", r, 64'h11223344AAAAAAAA);
    txn(1, 1'b0, 64'h2000, 64'h0, 8'h00, 0, "load_oor", r, e);
    chk("load_oor/err", 64'(e), 64'h1);
    chk("load_oor/rdata", r, 64'h0);
    txn(1, 1'b0, 64'h0, 64'h0, 8'h00, 0, "word0_before", r, e);
    v = r;
    txn(1, 1'b1, 64'h2000, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, "store_oor", r, e);
    chk("store_oor/err", 64'(e), 64'h1);
    txn(1, 1'b0, 64'h0, 64'h0, 8'h00, 0, "word0_after", r, e);
    chk("store_oor/word0_kept", r, v);
    txn(1, 1'b1, LIMIT - 64'd8, 64'h0F1E2D3C4B5A6978, 8'hFF, 0, "store_top", r, e);
    txn(1, 1'b0, LIMIT - 64'd1, 64'h0, 8'h00, 0, "load_top", r, e);
    chk("load_top/value", r, 64'h0F1E2D3C4B5A6978);
    chk("load_top/err", 64'(e), 64'h0);
    txn(1, 1'b0, 64'h10, 64'h0, 8'h00, 5, "hold5", r, e);

    // Randomised back-to-back traffic on every latency.
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 40; t++) begin
        w = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0:       a = LIMIT + 64'($urandom_range(0, 4095));
          1:       a = {1'b1, 31'($urandom), 32'($urandom)};
          default: a = (64'($urandom_range(0, NW - 1)) << 3) | 64'($urandom_range(0, 7));
        endcase
        txn(k, w, a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), "rand", r, e);
      end
    end

    // Reset while LAT=7 instance is in WAIT; the committed store must survive.
    v = 64'h5A5A_0123_4567_A5A5;
    req_valid[2] = 1'b1;
    req_wen[2]   = 1'b1;
    req_addr[2]  = 64'd20 << 3;
    req_wdata[2] = v;
    req_wmask[2] = 8'hFF;
    @(posedge clk);
    #1;
    model[2][20] = v;
    drive_idle(2);
    repeat (2) @(negedge clk);
    chk("rst_mid/in_wait", 64'(rsp_valid[2]), 64'h0);
    rst[2] = 1'b1;
    @(negedge clk);
    chk("rst_mid/rsp_valid", 64'(rsp_valid[2]), 64'h0);
    chk("rst_mid/rsp_rdata", rsp_rdata[2], 64'h0);
    chk("rst_mid/rsp_err", 64'(rsp_err[2]), 64'h0);
    rst[2] = 1'b0;
    @(negedge clk);
    chk("rst_mid/req_ready", 64'(req_ready[2]), 64'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_mid/no_rsp", 64'(rsp_valid[2]), 64'h0);
    end
    txn(2, 1'b0, 64'd20 << 3, 64'h0, 8'h00, 0, "rst_mid_load", r, e);
    chk("rst_mid/store_kept", r, 64'h5A5A_0123_4567_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
